// File: rtl/dm_wait.sv
// Data memory with programmable access latency, req/rdy handshake, sub-word stores and extending loads.
// Optional misaligned-access trap enabled by defining DM_WAIT_MISALIGN_TRAP_EN.
module dm_wait #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        busy,
    output logic        rdy,
    output logic [31:0] dout,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rdy_q, rdy_d;
    logic                  err_q, err_d;
    logic [31:0]           dout_q, dout_d;
    logic                  we_q;
    logic [5:0]            op_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           din_q;
    logic [31:0]           rdata_q;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [1:0]            lane;
    logic                  byte_op, half_op, word_op;
    logic                  trap;
    logic                  complete;
    logic                  do_write;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_val;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    assign idx_q   = addr_q[ADDR_WIDTH+1:2];
    assign lane    = addr_q[1:0];
    assign byte_op = we_q ? (op_q == OP_SB) : ((op_q == OP_LB) || (op_q == OP_LBU));
    assign half_op = we_q ? (op_q == OP_SH) : ((op_q == OP_LH) || (op_q == OP_LHU));
    assign word_op = !byte_op && !half_op;

`ifdef DM_WAIT_MISALIGN_TRAP_EN
    assign trap = (half_op && addr_q[0]) || (word_op && (addr_q[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign complete = (state_q == S_BUSY) && (cnt_q == 4'd0);
    assign do_write = complete && we_q && !trap && !rst;

    // Read port follows the live address while idle so the word is already
    // registered by the completion edge, even with LATENCY=1.
    assign rd_idx = (state_q == S_IDLE) ? addr[ADDR_WIDTH+1:2] : idx_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign be[gi] = byte_op ? (lane == 2'(gi))
                          : half_op ? (addr_q[1] == gi[1])
                          : 1'b1;
            assign wdata[gi*8 +: 8] = byte_op ? din_q[7:0]
                                    : half_op ? din_q[(gi%2)*8 +: 8]
                                    : din_q[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx_q][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        rdata_q <= mem[rd_idx];
    end

    assign byte_sel = rdata_q[lane*8 +: 8];
    assign half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        load_val = rdata_q;
        case (op_q)
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'd0, byte_sel};
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'd0, half_sel};
            default: load_val = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdy_d   = 1'b1;
                    err_d   = trap;
                    state_d = S_DONE;
                    if (!we_q && !trap) begin
                        dout_d = load_val;
                    end
                end
            end
            S_DONE: begin
                rdy_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Request fields are frozen at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req) begin
            we_q   <= we;
            op_q   <= op;
            addr_q <= addr[ADDR_WIDTH+1:0];
            din_q  <= din;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign rdy  = rdy_q;
    assign dout = dout_q;

`ifdef DM_WAIT_MISALIGN_TRAP_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_wait.sv
// Directed self-checking bench for dm_wait (ADDR_WIDTH=10, LATENCY=2).
module tb_dm_wait;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] din = 32'd0;
    logic        busy, rdy, err;
    logic [31:0] dout;

    int errors = 0;
    int checks = 0;

    int          lat;
    logic        busy1;
    logic [31:0] dv;
    logic        ev;

    dm_wait #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .we   (we),
        .op   (op),
        .addr (addr),
        .din  (din),
        .busy (busy),
        .rdy  (rdy),
        .dout (dout),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Issues one request, scrambles the inputs after acceptance and waits (bounded) for rdy.
    // lat = number of falling edges after the accept edge at which rdy is first seen, -1 on timeout.
    task automatic do_access(input logic w, input logic [5:0] o, input logic [31:0] a,
                             input logic [31:0] d, output int l, output logic b1,
                             output logic [31:0] dval, output logic eval);
        @(negedge clk);
        req = 1'b1; we = w; op = o; addr = a; din = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = ~w; op = 6'h3f; addr = ~a; din = ~d;
        b1 = busy;
        l = -1;
        dval = 'x;
        eval = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (rdy === 1'b1) begin
                l = k;
                dval = dout;
                eval = err;
                break;
            end
        end
        @(negedge clk);
        we = 1'b0; op = OP_LW; addr = 32'd0; din = 32'd0;
        $display("txn we=%0d op=%b addr=%h din=%h -> lat=%0d dout=%h err=%b",
                 w, o, a, d, l, dval, eval);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rdy !== 1'b0 || dout !== 32'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rdy=%b dout=%h err=%b, required 0 0 00000000 0",
                     busy, rdy, dout, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        do_access(1'b1, OP_SW, 32'h10, 32'hA1B2C3D4, lat, busy1, dv, ev);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL sw_busy_after_accept: got %b, required 1", busy1);
        end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL sw_rdy_latency: got %0d, required 3", lat);
        end
        checks++;
        if (rdy !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL sw_rdy_one_cycle: rdy=%b busy=%b, required 0 0", rdy, busy);
        end
        checks++;
        if (dv !== 32'd0) begin
            errors++; $display("FAIL sw_dout_unchanged: got %h, required 00000000", dv);
        end
        do_access(1'b0, OP_LW, 32'h10, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'hA1B2C3D4 || lat !== 3) begin
            errors++; $display("FAIL lw_0x10: got %h lat=%0d, required a1b2c3d4 lat=3", dv, lat);
        end
    endtask

    task automatic test_byte();
        do_access(1'b1, OP_SB, 32'h12, 32'h000000EE, lat, busy1, dv, ev);
        do_access(1'b0, OP_LW, 32'h10, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'hA1EEC3D4) begin
            errors++; $display("FAIL sb_lane2_word: got %h, required a1eec3d4", dv);
        end
        do_access(1'b0, OP_LB, 32'h12, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'hFFFFFFEE) begin
            errors++; $display("FAIL lb_0x12: got %h, required ffffffee", dv);
        end
        do_access(1'b0, OP_LBU, 32'h12, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h000000EE) begin
            errors++; $display("FAIL lbu_0x12: got %h, required 000000ee", dv);
        end
        do_access(1'b0, OP_LB, 32'h13, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'hFFFFFFA1) begin
            errors++; $display("FAIL lb_0x13: got %h, required ffffffa1", dv);
        end
        do_access(1'b0, OP_LB, 32'h10, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'hFFFFFFD4) begin
            errors++; $display("FAIL lb_0x10: got %h, required ffffffd4", dv);
        end
        do_access(1'b0, OP_LBU, 32'h11, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h000000C3) begin
            errors++; $display("FAIL lbu_0x11: got %h, required 000000c3", dv);
        end
    endtask

    task automatic test_half();
        do_access(1'b1, OP_SW, 32'h20, 32'h11223344, lat, busy1, dv, ev);
        do_access(1'b1, OP_SH, 32'h22, 32'h00008001, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h000000C3) begin
            errors++; $display("FAIL sh_dout_unchanged: got %h, required 000000c3", dv);
        end
        do_access(1'b0, OP_LW, 32'h20, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h80013344) begin
            errors++; $display("FAIL sh_upper_word: got %h, required 80013344", dv);
        end
        do_access(1'b0, OP_LH, 32'h22, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'hFFFF8001) begin
            errors++; $display("FAIL lh_0x22: got %h, required ffff8001", dv);
        end
        do_access(1'b0, OP_LHU, 32'h22, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h00008001) begin
            errors++; $display("FAIL lhu_0x22: got %h, required 00008001", dv);
        end
        do_access(1'b0, OP_LH, 32'h20, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h00003344) begin
            errors++; $display("FAIL lh_0x20: got %h, required 00003344", dv);
        end
        do_access(1'b1, OP_SH, 32'h20, 32'h0000BEEF, lat, busy1, dv, ev);
        do_access(1'b0, OP_LW, 32'h20, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h8001BEEF) begin
            errors++; $display("FAIL sh_lower_word: got %h, required 8001beef", dv);
        end
    endtask

    task automatic test_reset_busy();
        logic rdy_seen;
        do_access(1'b1, OP_SW, 32'h30, 32'h00000000, lat, busy1, dv, ev);
        @(negedge clk);
        req = 1'b1; we = 1'b1; op = OP_SW; addr = 32'h30; din = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rdy !== 1'b0) begin
            errors++; $display("FAIL reset_in_busy: busy=%b rdy=%b, required 0 0", busy, rdy);
        end
        rst = 1'b0;
        rdy_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdy === 1'b1) rdy_seen = 1'b1;
        end
        checks++;
        if (rdy_seen !== 1'b0) begin
            errors++; $display("FAIL reset_discard_rdy: rdy pulsed=%b, required 0", rdy_seen);
        end
        $display("txn reset during busy sw addr=00000030 din=deadbeef -> rdy_pulsed=%b", rdy_seen);
        do_access(1'b0, OP_LW, 32'h30, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h00000000) begin
            errors++; $display("FAIL reset_discard_mem: got %h, required 00000000", dv);
        end
    endtask

    task automatic test_back_to_back();
        int n_rdy;
        int first_rdy;
        int last_rdy;
        logic spacing_ok;
        n_rdy = 0; first_rdy = -1; last_rdy = -1; spacing_ok = 1'b1;
        @(negedge clk);
        req = 1'b1; we = 1'b1; op = OP_SW; addr = 32'h1004; din = 32'hCAFEF00D;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                if (last_rdy >= 0 && (k - last_rdy) != 4) spacing_ok = 1'b0;
                if (first_rdy < 0) first_rdy = k;
                last_rdy = k;
                n_rdy++;
            end
        end
        req = 1'b0;
        $display("txn held req sw addr=00001004 din=cafef00d -> completions=%0d first=%0d", n_rdy, first_rdy);
        checks++;
        if (n_rdy !== 4 || first_rdy !== 3 || spacing_ok !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: completions=%0d first=%0d spacing_ok=%b, required 4 3 1",
                     n_rdy, first_rdy, spacing_ok);
        end
        repeat (4) @(negedge clk);
        do_access(1'b0, OP_LW, 32'h4, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'hCAFEF00D) begin
            errors++; $display("FAIL addr_wrap: got %h, required cafef00d", dv);
        end
    endtask

    task automatic test_misalign();
        do_access(1'b1, OP_SW, 32'h40, 32'h55AA55AA, lat, busy1, dv, ev);
        do_access(1'b1, OP_SW, 32'h41, 32'h12345678, lat, busy1, dv, ev);
`ifdef DM_WAIT_MISALIGN_TRAP_EN
        checks++;
        if (ev !== 1'b1 || lat !== 3) begin
            errors++; $display("FAIL misalign_err: err=%b lat=%0d, required 1 3", ev, lat);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL misalign_err_clear: got %b, required 0", err);
        end
        do_access(1'b0, OP_LW, 32'h40, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h55AA55AA || ev !== 1'b0) begin
            errors++; $display("FAIL misalign_no_write: got %h err=%b, required 55aa55aa 0", dv, ev);
        end
`else
        checks++;
        if (ev !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL misalign_err: err=%b lat=%0d, required 0 3", ev, lat);
        end
        do_access(1'b0, OP_LW, 32'h40, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h12345678 || ev !== 1'b0) begin
            errors++; $display("FAIL misalign_ignored: got %h err=%b, required 12345678 0", dv, ev);
        end
        do_access(1'b0, OP_LHU, 32'h43, 32'h0, lat, busy1, dv, ev);
        checks++;
        if (dv !== 32'h00001234) begin
            errors++; $display("FAIL lhu_odd_addr: got %h, required 00001234", dv);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_reset_busy();
        test_back_to_back();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_wait.md
Name: dm_wait

Overview:
- Parametrised successor data memory for the MIPS CPU datapath.
- Sits in the memory stage between ALU address output and writeback mux.
- Adds configurable access latency with a req/rdy handshake, sub-word stores (sb/sh/sw) and sign/zero-extending loads (lb/lbu/lh/lhu/lw).
- Lets the pipeline or multicycle controller stall on memory.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words (default 4 KB)
LATENCY, 2, cycles spent in BUSY before the access completes; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  1  request strobe; sampled only in IDLE
we  input  1  1 = store, 0 = load
op  input  6  MIPS opcode selecting access size/extension
addr  input  32  byte address
din  input  32  store data (low byte/halfword used for sb/sh)
busy  output  1  1 whenever state != IDLE
rdy  output  1  one-cycle completion pulse
dout  output  32  load result, extended to 32 bits
err  output  1  misalignment flag, valid with rdy (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, busy=0, rdy=0, dout=0, err=0, counter=0.
  - Memory array is not cleared.
  - A reset during BUSY discards the pending access; no memory write occurs.
- Word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap modulo depth.
- Lane order: byte lane = addr[1:0]; lane 0 = bits [7:0], lane 3 = bits [31:24]; halfword lane = addr[1].
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - req=1 at edge E0 captures op/we/addr/din into internal registers.
    - counter <= LATENCY-1; go to BUSY.
    - req=0: stay in IDLE.
  - BUSY:
    - Each edge with counter!=0: decrement the counter.
    - At the edge with counter==0 (edge E_LATENCY), perform the access; rdy<=1; go to DONE.
  - DONE:
    - rdy=1 for exactly this cycle.
    - Next edge: rdy<=0; go to IDLE.
    - req asserted in BUSY or DONE is ignored; the requester must hold or re-assert req.
- Timing:
  - rdy is high in the cycle following E_LATENCY.
  - Minimum issue interval between accepted requests = LATENCY+2 cycles.
- Stores (we=1), memory written at the completion edge:
  - sb 101000: writes byte lane addr[1:0] with din[7:0].
  - sh 101001: writes halfword lane addr[1] with din[15:0].
  - Any other op: full word write with din.
  - Unwritten lanes are preserved.
  - dout is unchanged on store completion.
- Loads (we=0), dout registered at the completion edge:
  - lb 100000: sign-extend the selected byte.
  - lbu 100100: zero-extend the selected byte.
  - lh 100001: sign-extend the selected halfword.
  - lhu 100101: zero-extend the selected halfword.
  - Any other op: full word (lw).
- dout holds its value until the next load completion or reset.
- Captured request fields are used for the access; input changes after E0 have no effect.

Optional Feature:
- Macro: DM_WAIT_MISALIGN_TRAP_EN
- Defined:
  - Misalignment conditions: halfword ops (sh/lh/lhu) with addr[0]=1, or word ops (sw/lw/default) with addr[1:0]!=0.
  - On a misaligned access: err=1 for the rdy cycle, memory is not written, dout is unchanged.
  - err=0 otherwise; err clears with rdy.
- Undefined:
  - err is tied 0.
  - Halfword ops use addr[1] and ignore addr[0]; word ops ignore addr[1:0].

Test Plan:
1. Reset, then sw addr=0x10 din=0xA1B2C3D4 with LATENCY=2 -> busy=1 from the edge after req; rdy pulses exactly 3 cycles after the req edge for 1 cycle. lw 0x10 -> dout=0xA1B2C3D4.
2. After test 1, sb addr=0x12 din=0x000000EE, then lw 0x10 -> dout=0xA1EEC3D4. lb 0x12 -> 0xFFFFFFEE; lbu 0x12 -> 0x000000EE.
3. sh addr=0x22 din=0x00008001 over word 0x20 holding 0x11223344 -> word=0x80013344. lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001.
4. Assert rst two cycles after accepting sw addr=0x30 din=0xDEADBEEF (old word 0x0) -> busy=0, rdy never pulses; lw 0x30 -> 0x00000000.
5. Hold req=1 continuously -> exactly one acceptance per LATENCY+2 cycles. With ADDR_WIDTH=10, sw to 0x1004 followed by lw 0x4 -> same data (wrap).
6. With DM_WAIT_MISALIGN_TRAP_EN: sw addr=0x41 din=0x12345678 -> rdy=1 with err=1; lw 0x40 -> old contents, err=0. Without the macro: same sw -> word 0x40=0x12345678, err=0.
